// File: rtl/axis_rr_packet_arbiter_if.sv
// axis_rr_packet_arbiter_if: AXIS bundle between NUM_STREAMS slave streams and one shared master stream
//   axis_i_*  : concatenated slave streams (stream i at slice i), axis_i_tready returned per stream
//   axis_o_*  : arbitrated master stream, axis_o_tdest carries the source index
//   master    : arbiter view (consumes axis_i_*, produces axis_o_*)
//   slave     : endpoint view (sources drive axis_i_*, sink drives axis_o_tready)
interface axis_rr_packet_arbiter_if #(
  parameter int AXIS_BYTES = 1,
  parameter int AXIS_USER_BITS = 1,
  parameter int NUM_STREAMS = 4,
  parameter int IDX_W = NUM_STREAMS == 1 ? 1 : $clog2(NUM_STREAMS)
);
  logic [NUM_STREAMS*8*AXIS_BYTES-1:0] axis_i_tdata;
  logic [NUM_STREAMS*AXIS_BYTES-1:0] axis_i_tkeep;
  logic [NUM_STREAMS*AXIS_USER_BITS-1:0] axis_i_tuser;
  logic [NUM_STREAMS-1:0] axis_i_tlast;
  logic [NUM_STREAMS-1:0] axis_i_tvalid;
  logic [NUM_STREAMS-1:0] axis_i_tready;
  logic [8*AXIS_BYTES-1:0] axis_o_tdata;
  logic [AXIS_BYTES-1:0] axis_o_tkeep;
  logic [AXIS_USER_BITS-1:0] axis_o_tuser;
  logic [IDX_W-1:0] axis_o_tdest;
  logic axis_o_tlast;
  logic axis_o_tvalid;
  logic axis_o_tready;
  modport master (
    input axis_i_tdata, axis_i_tkeep, axis_i_tuser, axis_i_tlast, axis_i_tvalid, axis_o_tready,
    output axis_i_tready, axis_o_tdata, axis_o_tkeep, axis_o_tuser, axis_o_tdest, axis_o_tlast, axis_o_tvalid
  );
  modport slave (
    output axis_i_tdata, axis_i_tkeep, axis_i_tuser, axis_i_tlast, axis_i_tvalid, axis_o_tready,
    input axis_i_tready, axis_o_tdata, axis_o_tkeep, axis_o_tuser, axis_o_tdest, axis_o_tlast, axis_o_tvalid
  );
endinterface

// File: rtl/axis_rr_packet_arbiter.sv
// axis_rr_packet_arbiter: packet-level round-robin arbiter sharing one AXIS master among NUM_STREAMS slaves
//   clk, sreset      : clock and synchronous active-high reset
//   enable           : arbitration enable (an in-flight packet always completes)
//   stream_mask      : 1 = stream may be granted
//   bus              : AXIS slave streams in, arbitrated AXIS stream out (tdest = source index)
//   grant_idx        : current or last grant
//   busy             : high while a packet is being forwarded
//   frame_done       : one-cycle pulse after every PKTS_PER_FRAME-th packet
module axis_rr_packet_arbiter #(
  parameter int AXIS_BYTES = 1,
  parameter int AXIS_USER_BITS = 1,
  parameter int NUM_STREAMS = 4,
  parameter int PKTS_PER_FRAME = 4,
  localparam int IDX_W = NUM_STREAMS == 1 ? 1 : $clog2(NUM_STREAMS)
) (
  input  logic clk,
  input  logic sreset,
  input  logic enable,
  input  logic [NUM_STREAMS-1:0] stream_mask,
  axis_rr_packet_arbiter_if.master bus,
  output logic [IDX_W-1:0] grant_idx,
  output logic busy,
  output logic frame_done
);
  localparam int DW = 8 * AXIS_BYTES;
  localparam int CNT_W = PKTS_PER_FRAME < 2 ? 1 : $clog2(PKTS_PER_FRAME);
  typedef enum logic [1:0] {IDLE, ARB, XFER} state_t;
  state_t state;
  logic [IDX_W-1:0] last_idx, nxt;
  logic [CNT_W-1:0] pkt_cnt;
  logic [NUM_STREAMS-1:0] req;
  logic xfer, eop, wrap;
  assign req = bus.axis_i_tvalid & stream_mask;
  // descending scan so the lowest offset after last_idx wins
  always_comb begin
    nxt = last_idx;
    for (int k = NUM_STREAMS; k >= 1; k--)
      if (req[(int'(last_idx) + k) % NUM_STREAMS]) nxt = IDX_W'((int'(last_idx) + k) % NUM_STREAMS);
  end
  assign xfer = state == XFER;
  assign bus.axis_o_tdata = bus.axis_i_tdata[int'(grant_idx)*DW +: DW];
  assign bus.axis_o_tkeep = bus.axis_i_tkeep[int'(grant_idx)*AXIS_BYTES +: AXIS_BYTES];
  assign bus.axis_o_tuser = bus.axis_i_tuser[int'(grant_idx)*AXIS_USER_BITS +: AXIS_USER_BITS];
  assign bus.axis_o_tlast = bus.axis_i_tlast[grant_idx];
  assign bus.axis_o_tdest = grant_idx;
  assign bus.axis_o_tvalid = xfer & bus.axis_i_tvalid[grant_idx];
  assign bus.axis_i_tready = xfer ? NUM_STREAMS'(bus.axis_o_tready) << grant_idx : '0;
  assign eop = bus.axis_o_tvalid & bus.axis_o_tready & bus.axis_o_tlast;
  assign wrap = pkt_cnt == CNT_W'(PKTS_PER_FRAME - 1);
  always_ff @(posedge clk) begin
    if (sreset) begin
      state <= IDLE;
      grant_idx <= '0;
      last_idx <= IDX_W'(NUM_STREAMS - 1);
      pkt_cnt <= '0;
      busy <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        IDLE: if (enable) state <= ARB;
        ARB:
          if (!enable) state <= IDLE;
          else if (|req) begin
            grant_idx <= nxt;
            busy <= 1'b1;
            state <= XFER;
          end
        XFER:
          if (eop) begin
            last_idx <= grant_idx;
            pkt_cnt <= wrap ? '0 : pkt_cnt + 1'b1;
            frame_done <= wrap;
            busy <= 1'b0;
            state <= enable ? ARB : IDLE;
          end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_axis_rr_packet_arbiter.sv
// tb_axis_rr_packet_arbiter: directed self-checking bench for axis_rr_packet_arbiter (4 streams, 1-byte data)
module tb_axis_rr_packet_arbiter;
  logic clk = 1'b0;
  logic sreset, enable, busy, frame_done, rnd;
  logic [3:0] stream_mask, sv, gap;
  logic [1:0] grant_idx;
  int checks = 0, errors = 0, plen = 3, cyc = 0, nbeats = 0, npkts = 0, cur_len = 0, first_dest = 0;
  int seq[4], pno[4], exp_pkt[4];
  int pkt_dest[$], pkt_len[$], pkt_start[$], pkt_end[$], fd_q[$];
  logic [3:0] seen;
  always #5 clk = ~clk;
  axis_rr_packet_arbiter_if #(.NUM_STREAMS(4)) bus();
  axis_rr_packet_arbiter #(.NUM_STREAMS(4), .PKTS_PER_FRAME(4)) dut (
    .clk(clk), .sreset(sreset), .enable(enable), .stream_mask(stream_mask),
    .bus(bus), .grant_idx(grant_idx), .busy(busy), .frame_done(frame_done)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask
  // sources: beat data = {stream, packet number, beat index}; gaps only mid-packet
  always_comb
    for (int i = 0; i < 4; i++) begin
      bus.axis_i_tvalid[i] = sv[i] & ~(gap[i] & (seq[i] != 0));
      bus.axis_i_tdata[i*8 +: 8] = {2'(i), 3'(pno[i]), 3'(seq[i])};
      bus.axis_i_tkeep[i] = 1'b1;
      bus.axis_i_tuser[i] = seq[i] == 0;
      bus.axis_i_tlast[i] = seq[i] == plen - 1;
    end
  always @(posedge clk)
    for (int i = 0; i < 4; i++)
      if (sreset) begin
        seq[i] <= 0;
        pno[i] <= 0;
      end else if (bus.axis_i_tvalid[i] && bus.axis_i_tready[i]) begin
        seq[i] <= (seq[i] == plen - 1) ? 0 : seq[i] + 1;
        if (seq[i] == plen - 1) pno[i] <= pno[i] + 1;
      end
  // sink monitor: per-beat checks plus packet/frame logs
  always @(posedge clk) begin
    if (sreset) begin
      cur_len = 0;
      exp_pkt = '{default: 0};
    end else if (bus.axis_o_tvalid && bus.axis_o_tready) begin
      if (cur_len == 0) begin
        first_dest = int'(bus.axis_o_tdest);
        pkt_start.push_back(cyc);
      end
      chk("dest_hold", 32'(bus.axis_o_tdest), first_dest);
      chk("data", bus.axis_o_tdata, {bus.axis_o_tdest, 3'(exp_pkt[bus.axis_o_tdest]), 3'(cur_len)});
      chk("tuser", bus.axis_o_tuser, 32'(cur_len == 0));
      chk("tlast", bus.axis_o_tlast, 32'(cur_len == plen - 1));
      nbeats++;
      if (bus.axis_o_tlast) begin
        pkt_dest.push_back(int'(bus.axis_o_tdest));
        pkt_len.push_back(cur_len + 1);
        pkt_end.push_back(cyc);
        exp_pkt[bus.axis_o_tdest]++;
        npkts++;
        cur_len = 0;
      end else cur_len++;
    end
    if (frame_done) fd_q.push_back(cyc);
    seen |= bus.axis_i_tready;
    cyc++;
  end
  initial forever begin
    @(negedge clk);
    if (rnd) begin
      bus.axis_o_tready = 1'($urandom_range(0, 1));
      gap = 4'($urandom_range(0, 15));
    end
  end
  task automatic do_reset();
    sreset = 1'b1;
    repeat (2) @(negedge clk);
    pkt_dest.delete(); pkt_len.delete(); pkt_start.delete(); pkt_end.delete(); fd_q.delete();
    nbeats = 0;
    npkts = 0;
    seen = '0;
    sreset = 1'b0;
  endtask
  task automatic wait_pkts(input int n);
    int t = 0;
    while (npkts < n && t < 500) begin @(negedge clk); t++; end
    chk("pkt_timeout", 32'(npkts >= n), 1);
  endtask
  task automatic wait_beats(input int n);
    int t = 0;
    while (nbeats < n && t < 500) begin @(negedge clk); t++; end
    chk("beat_timeout", 32'(nbeats >= n), 1);
  endtask
  initial begin
    sreset = 1'b1; enable = 1'b0; rnd = 1'b0; gap = '0; sv = 4'hf; stream_mask = 4'hf; seen = '0;
    bus.axis_o_tready = 1'b1;
    // 1: reset state with every source valid
    repeat (3) @(negedge clk);
    chk("rst_tvalid", bus.axis_o_tvalid, 0);
    chk("rst_tready", bus.axis_i_tready, 0);
    chk("rst_grant", grant_idx, 0);
    chk("rst_busy", busy, 0);
    chk("rst_fdone", frame_done, 0);
    // 2: all valid, 3-beat packets
    do_reset();
    plen = 3; enable = 1'b1;
    wait_pkts(5);
    repeat (2) @(negedge clk);
    foreach (pkt_dest[k]) if (k < 5) chk($sformatf("rr_dest%0d", k), pkt_dest[k], k % 4);
    for (int k = 0; k < 5; k++) chk($sformatf("rr_len%0d", k), pkt_end[k] - pkt_start[k], 2);
    for (int k = 0; k < 4; k++) chk($sformatf("rr_bubble%0d", k), pkt_start[k+1] - pkt_end[k], 2);
    chk("fd_count", fd_q.size(), 1);
    chk("fd_cycle", fd_q[0], pkt_end[3] + 1);
    // 3: only streams 1 and 3 valid
    sv = 4'b1010; plen = 2;
    do_reset();
    wait_pkts(3);
    chk("alt0", pkt_dest[0], 1);
    chk("alt1", pkt_dest[1], 3);
    chk("alt2", pkt_dest[2], 1);
    chk("alt_seen02", seen & 4'b0101, 0);
    // 4: mask skips stream 2, bit 1 cleared mid-packet
    sv = 4'hf; plen = 3; stream_mask = 4'b1011;
    do_reset();
    wait_beats(4);
    stream_mask = 4'b1001;
    wait_pkts(5);
    chk("mask0", pkt_dest[0], 0);
    chk("mask1", pkt_dest[1], 1);
    chk("mask1_len", pkt_len[1], 3);
    chk("mask2", pkt_dest[2], 3);
    chk("mask3", pkt_dest[3], 0);
    chk("mask4", pkt_dest[4], 3);
    // 5: random sink stalls and mid-packet source gaps, 5-beat packets
    stream_mask = 4'hf; plen = 5;
    do_reset();
    rnd = 1'b1;
    wait_pkts(3);
    rnd = 1'b0; bus.axis_o_tready = 1'b1; gap = '0;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("rnd_dest%0d", k), pkt_dest[k], k);
      chk($sformatf("rnd_len%0d", k), pkt_len[k], 5);
    end
    // 6: enable drop mid-packet, then reset mid-packet
    plen = 4;
    do_reset();
    wait_beats(2);
    enable = 1'b0;
    repeat (8) @(negedge clk);
    chk("dis_pkts", npkts, 1);
    chk("dis_beats", nbeats, 4);
    chk("dis_len", pkt_len[0], 4);
    chk("dis_busy", busy, 0);
    chk("dis_tvalid", bus.axis_o_tvalid, 0);
    enable = 1'b1;
    wait_beats(6);
    sreset = 1'b1;
    @(negedge clk);
    chk("srst_tvalid", bus.axis_o_tvalid, 0);
    chk("srst_tready", bus.axis_i_tready, 0);
    chk("srst_busy", busy, 0);
    chk("srst_grant", grant_idx, 0);
    do_reset();
    wait_pkts(4);
    repeat (2) @(negedge clk);
    chk("srst_fd_count", fd_q.size(), 1);
    chk("srst_fd_cycle", fd_q[0], pkt_end[3] + 1);
    chk("srst_dest0", pkt_dest[0], 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
